// File: rtl/vector_writeback_buffer.sv
// Vector writeback buffer: queues execution-stage results with per-byte enables
// derived from SEW/VL/mask, and presents the oldest entry to the register file.
module vector_writeback_buffer #(
  parameter  int VLEN  = 128,
  parameter  int DEPTH = 4,
  localparam int NB    = VLEN / 8,
  localparam int VLW   = $clog2(NB) + 1,
  localparam int IW    = $clog2(NB),
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_vd_addr,
  input  logic [VLEN-1:0] in_data,
  input  logic [1:0]      in_sew,
  input  logic [VLW-1:0]  in_vl,
  input  logic            in_vm,
  input  logic [NB-1:0]   in_mask,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [VLEN-1:0] wr_data,
  output logic [NB-1:0]   wr_be,
  input  logic            wr_ack,
  output logic [CW-1:0]   count
);

  logic [4:0]      r_addr [DEPTH];
  logic [VLEN-1:0] r_data [DEPTH];
  logic [NB-1:0]   r_be   [DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;

  logic [NB-1:0]   w_be;
  logic            w_wrEn;
  logic            w_inReady;
  logic            w_push;
  logic            w_pop;

  // Byte b belongs to element b>>sew; elements past the register end never exist,
  // so VL saturation falls out of the per-byte comparison.
  always_comb begin : beCalc
    logic [IW-1:0] elemIdx;
    elemIdx = '0;
    w_be    = '0;
    for (int b = 0; b < NB; b++) begin
      elemIdx = IW'(b >> in_sew);
      w_be[b] = ({1'b0, elemIdx} < in_vl) && (in_vm || in_mask[elemIdx]);
    end
  end

  assign w_wrEn    = (r_count != '0);
  assign w_inReady = (r_count < CW'(DEPTH));
  assign w_pop     = w_wrEn && wr_ack;
  assign w_push    = in_valid && w_inReady && (|w_be);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Payload storage needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_wrPtr] <= in_vd_addr;
      r_data[r_wrPtr] <= in_data;
      r_be[r_wrPtr]   <= w_be;
    end
  end

  assign in_ready = w_inReady;
  assign wr_en    = w_wrEn;
  assign wr_addr  = w_wrEn ? r_addr[r_rdPtr] : '0;
  assign wr_data  = w_wrEn ? r_data[r_rdPtr] : '0;
  assign wr_be    = w_wrEn ? r_be[r_rdPtr]   : '0;
  assign count    = r_count;

endmodule

// File: tb/tb_vector_writeback_buffer.sv
// Randomized self-checking bench for vector_writeback_buffer against a queue-based
// reference model of the buffer contents and byte-enable rules.
module tb_vector_writeback_buffer;

  localparam int VLEN  = 128;
  localparam int DEPTH = 4;
  localparam int NB    = VLEN / 8;
  localparam int VLW   = $clog2(NB) + 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int HW    = 1 + 5 + NB + VLEN;

  logic            clock;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_vd_addr;
  logic [VLEN-1:0] in_data;
  logic [1:0]      in_sew;
  logic [VLW-1:0]  in_vl;
  logic            in_vm;
  logic [NB-1:0]   in_mask;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [VLEN-1:0] wr_data;
  logic [NB-1:0]   wr_be;
  logic            wr_ack;
  logic [CW-1:0]   count;

  typedef struct {
    logic [4:0]      addr;
    logic [VLEN-1:0] data;
    logic [NB-1:0]   be;
  } entry_t;

  entry_t model[$];
  int     checks;
  int     errors;

  vector_writeback_buffer #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vd_addr(in_vd_addr),
    .in_data   (in_data),
    .in_sew    (in_sew),
    .in_vl     (in_vl),
    .in_vm     (in_vm),
    .in_mask   (in_mask),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .wr_ack    (wr_ack),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Elements are 2^sew bytes; only the first min(vl, NB/esz) elements exist.
  function automatic logic [NB-1:0] modelBe(input logic [1:0] sew, input logic [VLW-1:0] vl,
                                            input logic vm, input logic [NB-1:0] mask);
    int esz, nel, act;
    logic [NB-1:0] be;
    esz = 1 << sew;
    nel = NB / esz;
    act = (int'(vl) > nel) ? nel : int'(vl);
    be  = '0;
    for (int i = 0; i < act; i++)
      if (vm || mask[i])
        for (int k = 0; k < esz; k++) be[i*esz+k] = 1'b1;
    return be;
  endfunction

  function automatic logic [HW-1:0] expectedHead();
    if (model.size() == 0) return '0;
    return {1'b1, model[0].addr, model[0].be, model[0].data};
  endfunction

  function automatic logic [VLEN-1:0] randVec();
    logic [VLEN-1:0] v;
    for (int w = 0; w < VLEN / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Entered at a falling edge; drives one cycle of inputs and advances the model.
  task automatic applyStimulus(input logic v, input logic [4:0] addr, input logic [VLEN-1:0] data,
                               input logic [1:0] sew, input logic [VLW-1:0] vl, input logic vm,
                               input logic [NB-1:0] mask, input logic ack);
    entry_t e;
    logic doPop, doAccept;
    in_valid = v; in_vd_addr = addr; in_data = data; in_sew = sew;
    in_vl = vl; in_vm = vm; in_mask = mask; wr_ack = ack;
    e.addr = addr; e.data = data; e.be = modelBe(sew, vl, vm, mask);
    doPop    = (model.size() != 0) && ack;
    doAccept = v && (model.size() < DEPTH);
    @(posedge clock);
    if (doPop) void'(model.pop_front());
    if (doAccept && (e.be != '0)) model.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input logic ack);
    applyStimulus(1'b0, 5'd0, '0, 2'd0, '0, 1'b1, '0, ack);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_vd_addr = '0; in_data = '0; in_sew = '0;
    in_vl = '0; in_vm = 1'b1; in_mask = '0; wr_ack = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (wr_be !== '0) begin errors++; $display("FAIL reset_wr_be: got %h expected 0", wr_be); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    applyStimulus(1'b1, 5'd3, 128'h0123456789ABCDEF0123456789ABCDEF, 2'd2, VLW'(4), 1'b1, '0, 1'b1);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr_en: got %0b expected 1", wr_en); end
    checks++; if (wr_addr !== 5'd3) begin errors++; $display("FAIL basic_wr_addr: got %0d expected 3", wr_addr); end
    checks++; if (wr_be !== 16'hFFFF) begin errors++; $display("FAIL basic_wr_be: got %h expected ffff", wr_be); end
    checks++; if (wr_data !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
      errors++; $display("FAIL basic_wr_data: got %h expected 0123456789abcdef0123456789abcdef", wr_data); end
    idle(1'b1);
    checks++; if (wr_en !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL basic_pop: got wr_en=%0b count=%0d expected 0/0", wr_en, count); end
  endtask

  task automatic test_masks();
    applyStimulus(1'b1, 5'd7, randVec(), 2'd0, VLW'(5), 1'b0, 16'h0015, 1'b0);
    checks++; if (wr_be !== 16'h0015) begin errors++; $display("FAIL mask_sew8_be: got %h expected 0015", wr_be); end
    applyStimulus(1'b1, 5'd9, randVec(), 2'd1, VLW'(3), 1'b1, '0, 1'b1);
    checks++; if (wr_be !== 16'h003F || wr_addr !== 5'd9 || count !== CW'(1)) begin
      errors++; $display("FAIL mask_sew16_be: got be=%h addr=%0d count=%0d expected 003f/9/1", wr_be, wr_addr, count); end
    idle(1'b1);
    checks++; if (count !== '0) begin errors++; $display("FAIL mask_drain: got %0d expected 0", count); end
  endtask

  task automatic test_zero_vl();
    applyStimulus(1'b1, 5'd4, randVec(), 2'd0, '0, 1'b1, '1, 1'b0);
    checks++; if (count !== '0 || wr_en !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_vl: got count=%0d wr_en=%0b in_ready=%0b expected 0/0/1", count, wr_en, in_ready); end
    applyStimulus(1'b1, 5'd4, randVec(), 2'd3, VLW'(2), 1'b0, 16'hFFFC, 1'b0);
    checks++; if (count !== '0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL all_masked: got count=%0d wr_en=%0b expected 0/0", count, wr_en); end
  endtask

  task automatic test_full();
    logic [VLEN-1:0] d5;
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, 5'(k + 8), randVec(), 2'($urandom_range(0, 3)), VLW'(NB), 1'b1, '0, 1'b0);
      checks++; if (count !== CW'(k + 1)) begin errors++; $display("FAIL full_fill: got %0d expected %0d", count, k + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", in_ready); end
    d5 = randVec();
    applyStimulus(1'b1, 5'd20, d5, 2'd0, VLW'(NB), 1'b1, '0, 1'b0);
    checks++; if (count !== CW'(4) || wr_addr !== 5'd8) begin
      errors++; $display("FAIL full_stall: got count=%0d head=%0d expected 4/8", count, wr_addr); end
    applyStimulus(1'b1, 5'd20, d5, 2'd0, VLW'(NB), 1'b1, '0, 1'b1);
    checks++; if (count !== CW'(3) || wr_addr !== 5'd9 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_no_bypass: got count=%0d head=%0d ready=%0b expected 3/9/1", count, wr_addr, in_ready); end
    applyStimulus(1'b1, 5'd20, d5, 2'd0, VLW'(NB), 1'b1, '0, 1'b1);
    checks++; if (count !== CW'(3) || wr_addr !== 5'd10) begin
      errors++; $display("FAIL full_fifth_accept: got count=%0d head=%0d expected 3/10", count, wr_addr); end
    for (int k = 0; k < DEPTH + 1 && model.size() != 0; k++) begin
      checks++; if ({wr_en, wr_addr, wr_be, wr_data} !== expectedHead()) begin
        errors++; $display("FAIL full_drain_head: got addr=%0d be=%h expected addr=%0d be=%h", wr_addr, wr_be, model[0].addr, model[0].be); end
      idle(1'b1);
    end
    checks++; if (count !== '0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL full_drained: got count=%0d wr_en=%0b expected 0/0", count, wr_en); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++)
      applyStimulus(1'b1, 5'(k + 1), randVec(), 2'd2, VLW'(NB), 1'b1, '0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checks++; if ({wr_en, wr_addr, wr_be, wr_data} !== expectedHead()) begin
        errors++; $display("FAIL b2b_head: got addr=%0d be=%h expected addr=%0d be=%h", wr_addr, wr_be, model[0].addr, model[0].be); end
      applyStimulus(1'b1, 5'(k + 12), randVec(), 2'($urandom_range(0, 3)), VLW'(NB), 1'b1, '0, 1'b1);
      checks++; if (count !== CW'(2)) begin errors++; $display("FAIL b2b_count: got %0d expected 2", count); end
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if ({wr_en, wr_addr, wr_be, wr_data} !== expectedHead()) begin
        errors++; $display("FAIL b2b_drain: got addr=%0d expected addr=%0d", wr_addr, model[0].addr); end
      idle(1'b1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      checks++; if (in_ready !== (model.size() < DEPTH)) begin
        errors++; $display("FAIL rand_ready: got %0b expected %0b", in_ready, model.size() < DEPTH); end
      checks++; if ({wr_en, wr_addr, wr_be, wr_data} !== expectedHead()) begin
        errors++; $display("FAIL rand_head: got en=%0b addr=%0d be=%h expected %h", wr_en, wr_addr, wr_be, expectedHead() >> VLEN); end
      applyStimulus(($urandom % 4) != 0, 5'($urandom), randVec(), 2'($urandom), VLW'($urandom_range(0, 20)),
                    1'($urandom), NB'($urandom), ($urandom % 2) == 0);
      checks++; if (count !== CW'(model.size())) begin
        errors++; $display("FAIL rand_count: got %0d expected %0d", count, model.size()); end
    end
    for (int k = 0; k < DEPTH + 1 && model.size() != 0; k++) idle(1'b1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 5'(k + 25), randVec(), 2'd1, VLW'(NB), 1'b1, '0, 1'b0);
    checks++; if (count !== CW'(3) || wr_en !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got count=%0d wr_en=%0b expected 3/1", count, wr_en); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || count !== '0 || in_ready !== 1'b1 || wr_be !== '0 || wr_addr !== 5'd0) begin
      errors++; $display("FAIL mid_async: got wr_en=%0b count=%0d ready=%0b be=%h expected 0/0/1/0", wr_en, count, in_ready, wr_be); end
    model.delete();
    wr_ack = 1'b1;
    @(negedge clock);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_held: got %0b expected 0", wr_en); end
    reset_n = 1'b1;
    idle(1'b1);
    checks++; if (count !== '0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL mid_after: got count=%0d wr_en=%0b expected 0/0", count, wr_en); end
    applyStimulus(1'b1, 5'd30, randVec(), 2'd3, VLW'(1), 1'b1, '0, 1'b0);
    checks++; if ({wr_en, wr_addr, wr_be, wr_data} !== expectedHead() || wr_be !== 16'h00FF) begin
      errors++; $display("FAIL mid_resume: got addr=%0d be=%h expected 30/00ff", wr_addr, wr_be); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_masks();
    test_zero_vl();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
